// File: rtl/shift_piso_tx.sv
// Parallel-in serial-out transmitter feeding an external LED SIPO register.
// Sends one word per handshake with a shift strobe per bit, then pulses the latch.
module shift_piso_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lr,
    output logic             s_out,
    output logic             shift_en,
    output logic             latch,
    output logic             busy,
    output logic             done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             lr_q, lr_nx;
    logic [BW-1:0]    bit_cnt, bit_nx;
    logic [DW-1:0]    div_cnt, div_nx;
    logic             s_out_nx, shift_en_nx, latch_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            lr_q     <= 1'b0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            s_out    <= 1'b0;
            shift_en <= 1'b0;
            latch    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            lr_q     <= lr_nx;
            bit_cnt  <= bit_nx;
            div_cnt  <= div_nx;
            s_out    <= s_out_nx;
            shift_en <= shift_en_nx;
            latch    <= latch_nx;
            done     <= latch_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        lr_nx    = lr_q;
        bit_nx   = bit_cnt;
        div_nx   = div_cnt;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    shreg_nx = data_in;
                    lr_nx    = lr;
                    bit_nx   = '0;
                    div_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    shreg_nx = lr_q ? (shreg >> 1) : (shreg << 1);
                    div_nx   = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nx   = '0;
                        state_nx = LATCH;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            LATCH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with the state they describe.
        s_out_nx    = 1'b0;
        if (state_nx == SHIFT)
            s_out_nx = lr_nx ? shreg_nx[0] : shreg_nx[WIDTH-1];
        shift_en_nx = (state_nx == SHIFT) && (div_nx == DIV_LAST);
        latch_nx    = (state_nx == LATCH);
    end

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_piso_tx.sv
// Directed bench for shift_piso_tx: a DIV=4 and a DIV=1 instance, per-cycle
// timing checks and a SIPO receiver model reconstructing each word.
module tb_shift_piso_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lv4 = 1'b0, lv1 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lr = 1'b0;
    logic       rdy4, so4, se4, la4, bz4, dn4;
    logic       rdy1, so1, se1, la1, bz1, dn1;
    bit         sel = 1'b0;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    shift_piso_tx #(.WIDTH(8), .DIV(4)) dut4 (
        .clk(clk), .reset(reset), .load_valid(lv4), .load_ready(rdy4),
        .data_in(data_in), .lr(lr), .s_out(so4), .shift_en(se4),
        .latch(la4), .busy(bz4), .done(dn4));

    shift_piso_tx #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(rdy1),
        .data_in(data_in), .lr(lr), .s_out(so1), .shift_en(se1),
        .latch(la1), .busy(bz1), .done(dn1));

    wire rdy_m = sel ? rdy1 : rdy4;
    wire so_m  = sel ? so1  : so4;
    wire se_m  = sel ? se1  : se4;
    wire la_m  = sel ? la1  : la4;
    wire bz_m  = sel ? bz1  : bz4;
    wire dn_m  = sel ? dn1  : dn4;

    typedef struct {
        logic [7:0] data;
        logic       lr;
        logic [7:0] seq;   // bits in send order, MSB = first bit on the line
        logic [7:0] word;  // word the receiver must hold after latch
    } vec_t;

    vec_t tbl[6];

    task automatic chk1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_so4"}, so4, 1'b0);  chk1({tag, "_se4"}, se4, 1'b0);
        chk1({tag, "_la4"}, la4, 1'b0);  chk1({tag, "_bz4"}, bz4, 1'b0);
        chk1({tag, "_dn4"}, dn4, 1'b0);  chk1({tag, "_rdy4"}, rdy4, 1'b1);
        chk1({tag, "_so1"}, so1, 1'b0);  chk1({tag, "_se1"}, se1, 1'b0);
        chk1({tag, "_la1"}, la1, 1'b0);  chk1({tag, "_rdy1"}, rdy1, 1'b1);
    endtask

    // Called at a negedge with the selected DUT idle. keep leaves load_valid
    // high afterwards; disturb drives a conflicting word mid-frame.
    task automatic run_frame(input logic [7:0] d, input logic l, input logic [7:0] es,
                             input logic [7:0] ex, input bit s, input bit keep, input bit disturb);
        int         div;
        int         n;
        int         k;
        logic [7:0] sipo;
        logic [7:0] seq;
        div  = s ? 1 : 4;
        n    = 8 * div;
        sipo = 8'h00;
        seq  = 8'h00;
        sel  = s;
        data_in = d;
        lr      = l;
        if (s) lv1 = 1'b1; else lv4 = 1'b1;
        chk1("ready_pre", rdy_m, 1'b1);
        @(posedge clk);
        #1;
        if (!keep) begin lv1 = 1'b0; lv4 = 1'b0; end
        for (int c = 1; c <= n + 2; c++) begin
            if (disturb && c == 10) begin
                data_in = 8'hFF; lr = ~l;
                if (s) lv1 = 1'b1; else lv4 = 1'b1;
            end
            if (disturb && c == 11) begin
                lv1 = 1'b0; lv4 = 1'b0;
            end
            @(negedge clk);
            k = (c - 1) / div;
            chk1("s_out", so_m, (c <= n) ? es[7 - k] : 1'b0);
            chk1("shift_en", se_m, (c <= n) && (c % div == 0));
            chk1("latch", la_m, c == n + 1);
            chk1("done", dn_m, c == n + 1);
            chk1("busy", bz_m, c <= n + 1);
            chk1("load_ready", rdy_m, c == n + 2);
            if (se_m) begin
                seq  = {seq[6:0], so_m};
                sipo = l ? {so_m, sipo[7:1]} : {sipo[6:0], so_m};
            end
        end
        chk8("seq", seq, es);
        chk8("sipo_word", sipo, ex);
    endtask

    initial begin
        int seen;
        int budget;

        tbl[0] = '{data: 8'hA5, lr: 1'b1, seq: 8'b10100101, word: 8'hA5};
        tbl[1] = '{data: 8'hC3, lr: 1'b0, seq: 8'b11000011, word: 8'hC3};
        tbl[2] = '{data: 8'h01, lr: 1'b1, seq: 8'b10000000, word: 8'h01};
        tbl[3] = '{data: 8'h01, lr: 1'b0, seq: 8'b00000001, word: 8'h01};
        tbl[4] = '{data: 8'h80, lr: 1'b1, seq: 8'b00000001, word: 8'h80};
        tbl[5] = '{data: 8'h3C, lr: 1'b1, seq: 8'b00111100, word: 8'h3C};

        #2;
        check_reset_outputs("rst_init");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].data, tbl[i].lr, tbl[i].seq, tbl[i].word, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)
            run_frame(tbl[i].data, tbl[i].lr, tbl[i].seq, tbl[i].word, 1'b1, 1'b0, 1'b0);

        // Back-to-back with load_valid held: second accept 34 cycles after the first.
        run_frame(8'h01, 1'b1, 8'b10000000, 8'h01, 1'b0, 1'b1, 1'b0);
        run_frame(8'h80, 1'b1, 8'b00000001, 8'h80, 1'b0, 1'b0, 1'b0);

        // Inputs ignored while busy.
        run_frame(8'hA5, 1'b1, 8'b10100101, 8'hA5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Reset mid-frame after the third shift_en.
        sel = 1'b0;
        data_in = 8'hC3; lr = 1'b0; lv4 = 1'b1;
        @(posedge clk);
        #1;
        lv4 = 1'b0;
        seen = 0;
        budget = 0;
        while (seen < 3 && budget < 100) begin
            @(negedge clk);
            budget++;
            if (se4) seen++;
            chk1("latch_pre_abort", la4, 1'b0);
        end
        chk1("third_shift_seen", seen == 3, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("latch_in_reset", la4, 1'b0);
            chk1("done_in_reset", dn4, 1'b0);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("latch_post_reset", la4, 1'b0);
            chk1("ready_post_reset", rdy4, 1'b1);
        end
        run_frame(8'h3C, 1'b1, 8'b00111100, 8'h3C, 1'b1, 1'b0, 1'b0);
        run_frame(8'h5A, 1'b0, 8'b01011010, 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_piso_tx.md
# shift_piso_tx

Parallel-in serial-out transmitter for the LED effect path: accepts a parallel pattern word through a valid/ready handshake and serializes it onto a one-bit line with a shift strobe. After the last bit it pulses a latch strobe. It is the feeding end for the 8-bit serial-in LED shift register, so that register holds exactly the accepted word after the latch pulse. Bit order follows a direction input captured at accept time.

## Interface
- WIDTH, 8: word length in bits; ≥2.
- DIV, 4: clock cycles per serial bit; ≥1.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- load_valid  input  1  word present on data_in.
- load_ready  output  1  block can accept; high exactly in IDLE.
- data_in  input  WIDTH  parallel pattern.
- lr  input  1  direction, sampled at accept; 1 = receiver shifts right (LSB sent first), 0 = receiver shifts left (MSB sent first).
- s_out  output  1  serial data, registered.
- shift_en  output  1  one-cycle strobe; the receiver samples s_out while it is high.
- latch  output  1  one-cycle strobe after the final bit.
- busy  output  1  high in SHIFT and LATCH.
- done  output  1  one-cycle pulse, coincident with latch.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE
  - load_ready=1.
  - On a clock edge with load_valid=1:
    - capture data_in into shreg and lr into lr_q;
    - bit_cnt=0, div_cnt=0;
    - go to SHIFT.
- SHIFT
  - Bit selection: s_out = shreg[0] when lr_q=1, else shreg[WIDTH-1].
  - After each bit, shreg shifts toward the sent end:
    - right (>>1) when lr_q=1;
    - left (<<1) when lr_q=0.
  - div_cnt counts 0..DIV-1. shift_en=1 only on the cycle with div_cnt=DIV-1.
  - On that cycle, at the edge: shreg shifts, div_cnt wraps to 0, and bit_cnt increments.
  - When bit_cnt=WIDTH-1 and div_cnt=DIV-1, go to LATCH.
- LATCH
  - Lasts one cycle with latch=1 and done=1.
  - s_out=0.
  - Then go to IDLE.
- Resulting order: lr_q=1 sends data[0] first; lr_q=0 sends data[WIDTH-1] first. Either way, the receiver shifting in the same direction ends holding data_in.
- load_valid, data_in and lr are ignored outside IDLE. No queuing.
- Counter widths: div_cnt uses clog2(DIV) bits, minimum 1. bit_cnt uses clog2(WIDTH) bits. Neither counter wraps past its terminal value.

## Timing
- Reset values, applied immediately and asynchronously:
  - state=IDLE;
  - s_out=0, shift_en=0, latch=0, busy=0, done=0;
  - load_ready=1;
  - shreg=0, all counters 0.
- All outputs are registered except load_ready and busy, which are decoded from state.
- Accept at edge E0.
  - Cycles 1..WIDTH·DIV: SHIFT.
  - Bit k (k=0..WIDTH-1) is held on s_out for cycles k·DIV+1 .. (k+1)·DIV.
  - shift_en is high in cycle (k+1)·DIV.
  - Cycle WIDTH·DIV+1: LATCH (latch=done=1).
  - Cycle WIDTH·DIV+2: IDLE, load_ready=1.
- Throughput: with load_valid held high, accepts are spaced WIDTH·DIV+2 cycles apart (one IDLE cycle between words).
- s_out changes only at bit boundaries. It is stable for all DIV cycles of a bit, including the shift_en cycle.
- DIV=1: shift_en is high on every SHIFT cycle, and s_out changes every cycle.
- Reset mid-SHIFT or mid-LATCH: abort at once with no latch pulse and no partial done. The next word is accepted normally after reset deasserts.

## Test plan
- Reset: assert reset mid-cycle -> all outputs at reset values within the same cycle; load_ready=1.
- Right shift (WIDTH=8, DIV=4, data_in=8'hA5, lr=1):
  - s_out sequence 1,0,1,0,0,1,0,1;
  - shift_en at cycles 4,8,…,32; latch and done at cycle 33;
  - an attached 8-bit right-shifting SIPO model holds 8'hA5.
- Left shift (data_in=8'hC3, lr=0):
  - s_out sequence 1,1,0,0,0,0,1,1;
  - left-shifting SIPO model holds 8'hC3 after latch.
- Back-to-back: load_valid held high with words 8'h01 then 8'h80 -> accepts 34 cycles apart; no extra shift_en pulses; both words reconstructed.
- Ignore while busy: during SHIFT, change data_in to 8'hFF and lr, pulse load_valid -> serialized word and order unchanged; load_ready=0 throughout.
- Reset mid-frame: assert reset after the 3rd shift_en -> latch is never pulsed; then an 8'h3C transfer with DIV=1 completes in 9 cycles from accept, with shift_en on 8 consecutive cycles.
